// File: rtl/pong_pkg.sv
// Shared Pong constants, game state encoding and score helper.
// Latency: n/a (package only).
// Backpressure: n/a.
// Used by the game controller, the vga timing generator and the pixel renderer.
package pong_pkg;

    // Screen and object geometry, in pixels
    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int BALL_SIZE    = 8;
    localparam int PADDLE_H     = 64;
    localparam int PADDLE_W     = 8;
    localparam int PADDLE_L_X   = 16;
    localparam int PADDLE_R_X   = 616;

    // Motion and game rules, per frame
    localparam int PADDLE_STEP  = 4;
    localparam int BALL_SPEED   = 2;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 9;

    // Start-of-game positions (ball centred, paddles centred)
    localparam logic [9:0] BALL_X0   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] PADDLE_Y0 = 10'((V_ACTIVE - PADDLE_H) / 2);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_GAMEOVER = 3'd3
    } game_state_t;

    // Score increment that sticks at the winning score instead of wrapping
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        if (s >= 4'(WIN_SCORE)) begin
            return 4'(WIN_SCORE);
        end
        return s + 4'd1;
    endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// Saturating vertical paddle position, one step per enabled frame tick.
// Latency: new y visible the cycle after the tick that computed it.
// Backpressure: none; y holds on cycles without tick.
// Ports: clk, rst (sync, active-high), tick (frame pulse), en (motion allowed),
//        ctr (recentre on this tick), up/dn (level buttons), y (top edge).
module paddle_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       en,
    input  logic       ctr,
    input  logic       up,
    input  logic       dn,
    output logic [9:0] y
);

    localparam logic [9:0] STEP  = 10'(PADDLE_STEP);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - PADDLE_H);

    logic [9:0] r_y;
    logic [9:0] w_y_nxt;

    // Both buttons held cancel each other out
    always_comb begin
        w_y_nxt = r_y;
        if (ctr) begin
            w_y_nxt = PADDLE_Y0;
        end else if (en && up && !dn) begin
            w_y_nxt = (r_y < STEP) ? 10'd0 : (r_y - STEP);
        end else if (en && dn && !up) begin
            w_y_nxt = (r_y > (Y_MAX - STEP)) ? Y_MAX : (r_y + STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= PADDLE_Y0;
        end else if (tick) begin
            r_y <= w_y_nxt;
        end
    end

    assign y = r_y;

endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame Pong sequencer: ball, paddles, scores and game state machine.
// Latency: all outputs update the cycle after frame_tick and hold otherwise.
// Backpressure: none; one update per frame_tick, rst overrides at any cycle.
// Ports: clk, rst (sync, active-high), frame_tick, start_btn, l_up/l_dn,
//        r_up/r_dn; outputs ball_x/ball_y, paddle_l_y/paddle_r_y,
//        score_l/score_r, game_state (game_state_t encoding).
module pong_game_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       l_up,
    input  logic       l_dn,
    input  logic       r_up,
    input  logic       r_dn,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] game_state
);

    // Signed edge constants for the 11-bit next-position compares
    localparam logic signed [10:0] S_SPD    = 11'(BALL_SPEED);
    localparam logic signed [10:0] S_ZERO   = 11'sd0;
    localparam logic signed [10:0] S_L_EDGE = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic signed [10:0] S_R_EDGE = 11'(PADDLE_R_X - BALL_SIZE);
    localparam logic signed [10:0] S_X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] S_Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [5:0]         SERVE_LAST = 6'(SERVE_FRAMES - 1);

    game_state_t r_state, w_state_nxt;

    logic [9:0] r_ball_x, r_ball_y, w_ball_x_nxt, w_ball_y_nxt;
    logic       r_dx_neg, r_dy_neg, w_dx_neg_nxt, w_dy_neg_nxt;
    logic [3:0] r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;

    logic [9:0]        w_pl_y, w_pr_y;
    logic              w_pad_en, w_pad_ctr;
    logic signed [10:0] w_nx, w_ny;
    logic              w_ovl_l, w_ovl_r, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
    logic [3:0]        w_sl_inc, w_sr_inc;

    paddle_ctrl u_pad_l (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick),
        .en   (w_pad_en),
        .ctr  (w_pad_ctr),
        .up   (l_up),
        .dn   (l_dn),
        .y    (w_pl_y)
    );

    paddle_ctrl u_pad_r (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick),
        .en   (w_pad_en),
        .ctr  (w_pad_ctr),
        .up   (r_up),
        .dn   (r_dn),
        .y    (w_pr_y)
    );

    // Candidate ball position; one extra bit so moves past 0 go negative
    assign w_nx = r_dx_neg ? ($signed({1'b0, r_ball_x}) - S_SPD)
                           : ($signed({1'b0, r_ball_x}) + S_SPD);
    assign w_ny = r_dy_neg ? ($signed({1'b0, r_ball_y}) - S_SPD)
                           : ($signed({1'b0, r_ball_y}) + S_SPD);

    // Vertical overlap uses the pre-tick ball and paddle positions
    assign w_ovl_l = (({1'b0, r_ball_y} + 11'(BALL_SIZE)) > {1'b0, w_pl_y}) &&
                     ({1'b0, r_ball_y} < ({1'b0, w_pl_y} + 11'(PADDLE_H)));
    assign w_ovl_r = (({1'b0, r_ball_y} + 11'(BALL_SIZE)) > {1'b0, w_pr_y}) &&
                     ({1'b0, r_ball_y} < ({1'b0, w_pr_y} + 11'(PADDLE_H)));

    // A paddle hit masks a miss computed in the same frame
    assign w_hit_l  = r_dx_neg  && (w_nx <= S_L_EDGE) && w_ovl_l;
    assign w_hit_r  = !r_dx_neg && (w_nx >= S_R_EDGE) && w_ovl_r;
    assign w_miss_l = (w_nx <= S_ZERO)  && !w_hit_l;
    assign w_miss_r = (w_nx >= S_X_MAX) && !w_hit_r;

    assign w_sl_inc = score_inc(r_score_l);
    assign w_sr_inc = score_inc(r_score_r);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (frame_tick) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (start_btn) w_state_nxt = ST_SERVE;
            ST_SERVE:    if (r_cnt == SERVE_LAST) w_state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (!w_hit_l && !w_hit_r) begin
                    if (w_miss_l) begin
                        w_state_nxt = (w_sr_inc == 4'(WIN_SCORE)) ? ST_GAMEOVER : ST_SERVE;
                    end else if (w_miss_r) begin
                        w_state_nxt = (w_sl_inc == 4'(WIN_SCORE)) ? ST_GAMEOVER : ST_SERVE;
                    end
                end
            end
            ST_GAMEOVER: if (start_btn) w_state_nxt = ST_SERVE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state datapath outputs
    always_comb begin
        w_ball_x_nxt  = r_ball_x;
        w_ball_y_nxt  = r_ball_y;
        w_dx_neg_nxt  = r_dx_neg;
        w_dy_neg_nxt  = r_dy_neg;
        w_score_l_nxt = r_score_l;
        w_score_r_nxt = r_score_r;
        w_cnt_nxt     = r_cnt;
        w_pad_en      = (r_state == ST_SERVE) || (r_state == ST_PLAY);
        w_pad_ctr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_btn) w_cnt_nxt = 6'd0;
            end
            ST_SERVE: begin
                w_cnt_nxt = (r_cnt == SERVE_LAST) ? 6'd0 : (r_cnt + 6'd1);
            end
            ST_PLAY: begin
                // Walls first; a paddle bounce below only touches x/dx
                if (w_ny <= S_ZERO) begin
                    w_ball_y_nxt = 10'd0;
                    w_dy_neg_nxt = 1'b0;
                end else if (w_ny >= S_Y_MAX) begin
                    w_ball_y_nxt = S_Y_MAX[9:0];
                    w_dy_neg_nxt = 1'b1;
                end else begin
                    w_ball_y_nxt = w_ny[9:0];
                end

                if (w_hit_l) begin
                    w_ball_x_nxt = S_L_EDGE[9:0];
                    w_dx_neg_nxt = 1'b0;
                end else if (w_hit_r) begin
                    w_ball_x_nxt = S_R_EDGE[9:0];
                    w_dx_neg_nxt = 1'b1;
                end else if (w_miss_l) begin
                    // Next serve heads toward the side that lost the point
                    w_score_r_nxt = w_sr_inc;
                    w_ball_x_nxt  = BALL_X0;
                    w_ball_y_nxt  = BALL_Y0;
                    w_dx_neg_nxt  = 1'b1;
                    w_cnt_nxt     = 6'd0;
                end else if (w_miss_r) begin
                    w_score_l_nxt = w_sl_inc;
                    w_ball_x_nxt  = BALL_X0;
                    w_ball_y_nxt  = BALL_Y0;
                    w_dx_neg_nxt  = 1'b0;
                    w_cnt_nxt     = 6'd0;
                end else begin
                    w_ball_x_nxt = w_nx[9:0];
                end
            end
            ST_GAMEOVER: begin
                if (start_btn) begin
                    w_score_l_nxt = 4'd0;
                    w_score_r_nxt = 4'd0;
                    w_ball_x_nxt  = BALL_X0;
                    w_ball_y_nxt  = BALL_Y0;
                    w_cnt_nxt     = 6'd0;
                    w_pad_ctr     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ball_x  <= BALL_X0;
            r_ball_y  <= BALL_Y0;
            r_dx_neg  <= 1'b0;
            r_dy_neg  <= 1'b0;
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
            r_cnt     <= 6'd0;
        end else if (frame_tick) begin
            r_ball_x  <= w_ball_x_nxt;
            r_ball_y  <= w_ball_y_nxt;
            r_dx_neg  <= w_dx_neg_nxt;
            r_dy_neg  <= w_dy_neg_nxt;
            r_score_l <= w_score_l_nxt;
            r_score_r <= w_score_r_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign ball_x     = r_ball_x;
    assign ball_y     = r_ball_y;
    assign paddle_l_y = w_pl_y;
    assign paddle_r_y = w_pr_y;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign game_state = r_state;

endmodule
